mio_ram16_arbiter: RTL and testbench

Memory-side sequencer that shares one 16-bit-wide synchronous RAM between the multi-cycle CPU's memory/IO port (CPU_MIO / mem_w / Half_W / MIO_ready handshake) and a second read-only requester (display/polling fetch). It grants one requester at a time, round-robin. It splits each 32-bit CPU access into two 16-bit RAM cycles and raises MIO_ready when the CPU transfer is complete. It sits between the CPU top level and the RAM macro.

---
 rtl/mio_ram16_arbiter_pkg.sv | 28 ++
 rtl/mio_ram16_arbiter_if.sv | 43 ++++
 rtl/mio_ram16_arbiter_rr_arb2.sv | 42 ++++
 rtl/mio_ram16_arbiter.sv | 151 +++++++++++++++
 tb/tb_mio_ram16_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mio_ram16_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mio_arb_pkg : state, owner and latency constants for the         |
// |               16-bit RAM arbiter                                 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mio_arb_pkg;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LO   = 3'd1;
  localparam state_t ST_HI   = 3'd2;
  localparam state_t ST_LAT  = 3'd3;
  localparam state_t ST_ACK  = 3'd4;

  typedef logic owner_t;
  localparam owner_t OWN_CPU = 1'b0;
  localparam owner_t OWN_DEV = 1'b1;

  // Cycles from the IDLE sampling edge to the ack-high cycle.
  localparam int LAT_WORD_RD = 4;
  localparam int LAT_WORD_WR = 3;
  localparam int LAT_HALF_RD = 3;
  localparam int LAT_HALF_WR = 2;
  localparam int LAT_DEV_RD  = 3;

endpackage
`default_nettype wire

// File: rtl/mio_ram16_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mio_ram16_arbiter_if : CPU port, device port and RAM port bundle |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mio_ram16_arbiter_if #(
  parameter int RAM_AW = 14
);
  logic              cpu_req;
  logic              cpu_we;
  logic              cpu_half;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              MIO_ready;

  logic              dev_req;
  logic [31:0]       dev_addr;
  logic [15:0]       dev_rdata;
  logic              dev_ack;

  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  logic [15:0]       ram_din;
  logic [15:0]       ram_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_half, cpu_addr, cpu_wdata,
    input  dev_req, dev_addr,
    input  ram_dout,
    output cpu_rdata, MIO_ready, dev_rdata, dev_ack,
    output ram_addr, ram_we, ram_din
  );

  modport master (
    output cpu_req, cpu_we, cpu_half, cpu_addr, cpu_wdata,
    output dev_req, dev_addr,
    output ram_dout,
    input  cpu_rdata, MIO_ready, dev_rdata, dev_ack,
    input  ram_addr, ram_we, ram_din
  );
endinterface
`default_nettype wire

// File: rtl/mio_ram16_arbiter_rr_arb2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arb2 : two-requester round-robin arbiter, grant on strobe     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rr_arb2
  import mio_arb_pkg::*;
(
  input  wire logic   clk,
  input  wire logic   reset,
  input  wire logic   strobe,
  input  wire logic   req_cpu,
  input  wire logic   req_dev,
  input  wire logic   done,
  input  wire owner_t done_owner,
  output logic        gnt_valid,
  output owner_t      gnt_owner
);

  owner_t last_q;
  owner_t last_d;

  always_comb begin
    last_d = last_q;
    if (done) last_d = done_owner;
  end

  // Resetting to "dev" makes the CPU win the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= OWN_DEV;
    else       last_q <= last_d;
  end

  always_comb begin
    gnt_valid = strobe && (req_cpu || req_dev);
    gnt_owner = OWN_CPU;
    if (req_cpu && req_dev) gnt_owner = (last_q == OWN_DEV) ? OWN_CPU : OWN_DEV;
    else if (req_dev)       gnt_owner = OWN_DEV;
  end

endmodule
`default_nettype wire

// File: rtl/mio_ram16_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mio_ram16_arbiter : shares a 16-bit sync RAM between the CPU MIO |
// |                     port and a read-only device fetch port       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mio_ram16_arbiter
  import mio_arb_pkg::*;
#(
  parameter int RAM_AW = 14
) (
  input wire logic            clk,
  input wire logic            reset,
  mio_ram16_arbiter_if.slave  bus
);

  state_t            state_q,     state_d;
  owner_t            owner_q,     owner_d;
  logic              we_q,        we_d;
  logic              half_q,      half_d;
  logic [15:0]       wdata_hi_q,  wdata_hi_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [15:0]       dev_rdata_q, dev_rdata_d;
  logic [RAM_AW-1:0] ram_addr_q,  ram_addr_d;
  logic              ram_we_q,    ram_we_d;
  logic [15:0]       ram_din_q,   ram_din_d;

  logic              gnt_valid;
  owner_t            gnt_owner;
  logic              arb_done;

  logic [31:0]       w_sel_addr;
  logic              w_sel_we;
  logic              w_sel_half;
  logic [RAM_AW-1:0] w_sel_ram_addr;

  // Bits above the RAM window and the byte-lane bit never reach the RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.cpu_addr[31:RAM_AW+1], bus.cpu_addr[0],
                              bus.dev_addr[31:RAM_AW+1], bus.dev_addr[0]};

  rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .strobe     (state_q == ST_IDLE),
    .req_cpu    (bus.cpu_req),
    .req_dev    (bus.dev_req),
    .done       (arb_done),
    .done_owner (owner_q),
    .gnt_valid  (gnt_valid),
    .gnt_owner  (gnt_owner)
  );

  // Device fetches are always single-halfword reads.
  assign w_sel_addr     = (gnt_owner == OWN_CPU) ? bus.cpu_addr : bus.dev_addr;
  assign w_sel_we       = (gnt_owner == OWN_CPU) && bus.cpu_we;
  assign w_sel_half     = (gnt_owner == OWN_DEV) || bus.cpu_half;
  assign w_sel_ram_addr = w_sel_half ? w_sel_addr[RAM_AW:1]
                                     : {w_sel_addr[RAM_AW:2], 1'b0};

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    half_d      = half_q;
    wdata_hi_d  = wdata_hi_q;
    cpu_rdata_d = cpu_rdata_q;
    dev_rdata_d = dev_rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_din_d   = ram_din_q;
    arb_done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          owner_d    = gnt_owner;
          we_d       = w_sel_we;
          half_d     = w_sel_half;
          wdata_hi_d = bus.cpu_wdata[31:16];
          ram_addr_d = w_sel_ram_addr;
          ram_we_d   = w_sel_we;
          if (w_sel_we) ram_din_d = bus.cpu_wdata[15:0];
          state_d    = ST_LO;
        end
      end
      ST_LO: begin
        if (!half_q) begin
          ram_addr_d = {ram_addr_q[RAM_AW-1:1], 1'b1};
          ram_we_d   = we_q;
          if (we_q) ram_din_d = wdata_hi_q;
          state_d    = ST_HI;
        end else begin
          state_d    = we_q ? ST_ACK : ST_LAT;
        end
      end
      ST_HI: begin
        // RAM output now carries the low halfword addressed during LO.
        if (!we_q) cpu_rdata_d[15:0] = bus.ram_dout;
        state_d = we_q ? ST_ACK : ST_LAT;
      end
      ST_LAT: begin
        if (owner_q == OWN_DEV) dev_rdata_d = bus.ram_dout;
        else if (half_q)        cpu_rdata_d = {16'h0000, bus.ram_dout};
        else                    cpu_rdata_d[31:16] = bus.ram_dout;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        arb_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      half_q      <= 1'b0;
      wdata_hi_q  <= '0;
      cpu_rdata_q <= '0;
      dev_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      half_q      <= half_d;
      wdata_hi_q  <= wdata_hi_d;
      cpu_rdata_q <= cpu_rdata_d;
      dev_rdata_q <= dev_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_din_q   <= ram_din_d;
    end
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dev_rdata = dev_rdata_q;
  assign bus.MIO_ready = (state_q == ST_ACK) && (owner_q == OWN_CPU);
  assign bus.dev_ack   = (state_q == ST_ACK) && (owner_q == OWN_DEV);
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_din   = ram_din_q;

endmodule
`default_nettype wire

// File: tb/tb_mio_ram16_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mio_ram16_arbiter : scoreboard bench with a halfword memory   |
// |                        model and randomized CPU/device traffic   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mio_ram16_arbiter;
  import mio_arb_pkg::*;

  localparam int RAM_AW    = 14;
  localparam int RAM_WORDS = 1 << RAM_AW;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    int          issue;
    int          lmin;
    int          lmax;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t cpu_q[$];
  exp_t dev_q[$];
  exp_t cpu_e;
  exp_t dev_e;

  logic [15:0] ram   [0:RAM_WORDS-1];
  logic [15:0] model [0:RAM_WORDS-1];

  mio_ram16_arbiter_if #(.RAM_AW(RAM_AW)) bus ();

  mio_ram16_arbiter #(.RAM_AW(RAM_AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM macro: read-before-write, data one cycle after address.
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= ram[bus.ram_addr];
  end

  function automatic logic [15:0] pat(input int i);
    logic [31:0] v;
    v = i * 40503;
    return v[15:0] ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_lat(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d cycles expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: pops the scoreboard whenever an ack is presented.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.MIO_ready || bus.dev_ack)
        check("ack_exclusive", {31'b0, bus.MIO_ready && bus.dev_ack}, 32'h0);
      if (bus.MIO_ready) begin
        if (cpu_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cpu_spurious_ack: got MIO_ready=1 expected no pending CPU access");
        end else begin
          cpu_e = cpu_q.pop_front();
          check_lat("cpu_latency", cyc - cpu_e.issue, cpu_e.lmin, cpu_e.lmax);
          if (cpu_e.chk) check("cpu_rdata", bus.cpu_rdata, cpu_e.exp);
        end
      end
      if (bus.dev_ack) begin
        if (dev_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dev_spurious_ack: got dev_ack=1 expected no pending device access");
        end else begin
          dev_e = dev_q.pop_front();
          check_lat("dev_latency", cyc - dev_e.issue, dev_e.lmin, dev_e.lmax);
          check("dev_rdata", {16'h0000, bus.dev_rdata}, dev_e.exp);
        end
      end
    end
  end

  // Called and returns at a negedge; leaves one idle cycle after the ack.
  task automatic cpu_xact(input bit we, input bit half, input logic [31:0] addr,
                          input logic [31:0] wdata, input int xmin, input int xmax,
                          input bit scramble);
    exp_t e;
    int   ha, base, lat, waited;
    ha   = int'((addr >> 1) % RAM_WORDS);
    base = int'(((addr >> 2) % (RAM_WORDS / 2)) * 2);
    e.chk = !we;
    e.exp = '0;
    if (we) begin
      if (half) model[ha] = wdata[15:0];
      else begin
        model[base]     = wdata[15:0];
        model[base + 1] = wdata[31:16];
      end
    end else begin
      e.exp = half ? {16'h0000, model[ha]} : {model[base + 1], model[base]};
    end
    lat    = we ? (half ? LAT_HALF_WR : LAT_WORD_WR) : (half ? LAT_HALF_RD : LAT_WORD_RD);
    e.lmin = lat + xmin;
    e.lmax = lat + xmax;
    e.issue = cyc;
    cpu_q.push_back(e);
    bus.cpu_we    = we;
    bus.cpu_half  = half;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_req   = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
      if (scramble && waited == 1) begin
        bus.cpu_addr  = $urandom;
        bus.cpu_wdata = $urandom;
      end
    end while (!bus.MIO_ready && waited < 40);
    if (!bus.MIO_ready) begin
      checks++; errors++;
      $display("FAIL cpu_timeout: got no MIO_ready expected one within 40 cycles");
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic dev_xact(input logic [31:0] addr, input int xmin, input int xmax);
    exp_t e;
    int   ha, waited;
    ha      = int'((addr >> 1) % RAM_WORDS);
    e.chk   = 1'b1;
    e.exp   = {16'h0000, model[ha]};
    e.lmin  = LAT_DEV_RD + xmin;
    e.lmax  = LAT_DEV_RD + xmax;
    e.issue = cyc;
    dev_q.push_back(e);
    bus.dev_addr = addr;
    bus.dev_req  = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.dev_ack && waited < 40);
    if (!bus.dev_ack) begin
      checks++; errors++;
      $display("FAIL dev_timeout: got no dev_ack expected one within 40 cycles");
    end
    bus.dev_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion before 200us");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    for (int i = 0; i < RAM_WORDS; i++) begin
      ram[i]   = pat(i);
      model[i] = pat(i);
    end
    reset         = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_half  = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dev_req   = 1'b0;
    bus.dev_addr  = '0;
    repeat (3) @(negedge clk);

    check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    check("rst_dev_rdata", {16'h0, bus.dev_rdata}, 32'h0);
    check("rst_mio_ready", {31'b0, bus.MIO_ready}, 32'h0);
    check("rst_dev_ack",   {31'b0, bus.dev_ack}, 32'h0);
    check("rst_ram_addr",  {18'b0, bus.ram_addr}, 32'h0);
    check("rst_ram_we",    {31'b0, bus.ram_we}, 32'h0);
    check("rst_ram_din",   {16'h0, bus.ram_din}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    cpu_xact(1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 0);
    check("word_wr_lo", {16'h0, ram[8]}, 32'h0000_BEEF);
    check("word_wr_hi", {16'h0, ram[9]}, 32'h0000_DEAD);
    cpu_xact(0, 0, 32'h0000_0010, 32'h0, 0, 0, 0);

    cpu_xact(1, 1, 32'h0000_0022, 32'h1234_5678, 0, 0, 0);
    check("half_wr",        {16'h0, ram[32'h11]}, 32'h0000_5678);
    check("half_wr_nbr",    {16'h0, ram[32'h10]}, {16'h0, pat(32'h10)});
    cpu_xact(0, 1, 32'h0000_0022, 32'h0, 0, 0, 0);

    cpu_xact(1, 0, 32'h0000_0000, 32'hCAFE_F00D, 0, 0, 0);
    dev_xact(32'h0000_4006, 0, 0);

    // Tie straight out of reset: CPU first, then CPU again after the device.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    fork
      cpu_xact(0, 0, 32'h0000_0010, 32'h0, 0, 0, 0);
      dev_xact(32'h0000_4002, 5, 5);
    join
    fork
      cpu_xact(0, 0, 32'h0000_8003, 32'h0, 0, 0, 0);
      dev_xact(32'h0000_7FFE, 5, 5);
    join

    // Reset lands in HI of a word write: only the low halfword reaches RAM.
    bus.cpu_we    = 1'b1;
    bus.cpu_half  = 1'b0;
    bus.cpu_addr  = 32'h0000_0040;
    bus.cpu_wdata = 32'hA5A5_5A5A;
    bus.cpu_req   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_ram_we", {31'b0, bus.ram_we}, 32'h0);
    check("rst_mid_ack",    {31'b0, bus.MIO_ready}, 32'h0);
    @(negedge clk); bus.cpu_req = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    model[32'h20] = 16'h5A5A;
    check("rst_mid_lo", {16'h0, ram[32'h20]}, 32'h0000_5A5A);
    check("rst_mid_hi", {16'h0, ram[32'h21]}, {16'h0, pat(32'h21)});
    cpu_xact(0, 0, 32'h0000_0040, 32'h0, 0, 0, 0);

    cpu_xact(1, 0, 32'h0000_0060, 32'h1111_2222, 0, 0, 1);
    check("latched_lo", {16'h0, ram[32'h30]}, 32'h0000_2222);
    check("latched_hi", {16'h0, ram[32'h31]}, 32'h0000_1111);
    cpu_xact(0, 0, 32'h0000_0060, 32'h0, 0, 0, 0);

    // Random concurrent traffic: CPU in the lower half of RAM, device in the upper.
    fork
      begin
        repeat (40) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a = $urandom;
          a[RAM_AW] = 1'b0;
          d = $urandom;
          cpu_xact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d, 0, 5, 0);
        end
      end
      begin
        logic [31:0] da;
        repeat (40) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          da = $urandom;
          da[RAM_AW] = 1'b1;
          dev_xact(da, 0, 5);
        end
      end
    join

    repeat (5) @(negedge clk);
    check("cpu_q_drained", cpu_q.size(), 32'h0);
    check("dev_q_drained", dev_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
